// File: rtl/cdc_sync_data_stable.sv
// Multi-channel receiver for quasi-static asynchronous words: per-channel synchroniser
// chain, stability filter and coherent whole-word output commit with a global freeze.
module cdc_sync_data_stable #(
  parameter int                 NUM_CHANNELS  = 2,
  parameter int                 NUM_BITS      = 2,
  parameter int                 SYNC_STAGES   = 2,
  parameter int                 STABLE_CYCLES = 4,
  parameter logic [NUM_BITS-1:0] INIT_VALUE   = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CHANNELS*NUM_BITS-1:0] bits_in,
  input  logic                             freeze,
  output logic [NUM_CHANNELS*NUM_BITS-1:0] bits_out,
  output logic [NUM_CHANNELS-1:0]          updated,
  output logic [NUM_CHANNELS-1:0]          stable
);

  localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef logic [NUM_BITS-1:0] word_t;

  generate
    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_param_check
      $error("cdc_sync_data_stable: SYNC_STAGES must be >= 2 and STABLE_CYCLES >= 1");
    end
  endgenerate

  word_t            sync_q [NUM_CHANNELS][SYNC_STAGES];
  word_t            sync_d [NUM_CHANNELS][SYNC_STAGES];
  word_t            p_q    [NUM_CHANNELS];
  word_t            p_d    [NUM_CHANNELS];
  word_t            out_q  [NUM_CHANNELS];
  word_t            out_d  [NUM_CHANNELS];
  logic [CNT_W-1:0] cnt_q  [NUM_CHANNELS];
  logic [CNT_W-1:0] cnt_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] updated_q, updated_d;
  logic [NUM_CHANNELS-1:0] stable_q, stable_d;

  // NOTE: every variable gets a default at the top of the block so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    word_t s_val;
    s_val     = '0;
    updated_d = '0;
    stable_d  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sync_d[c][0] = bits_in[c*NUM_BITS +: NUM_BITS];
      for (int n = 1; n < SYNC_STAGES; n++) begin
        sync_d[c][n] = sync_q[c][n-1];
      end
      s_val    = sync_q[c][SYNC_STAGES-1];
      p_d[c]   = p_q[c];
      cnt_d[c] = cnt_q[c];
      out_d[c] = out_q[c];

      if (s_val != p_q[c]) begin
        p_d[c]   = s_val;
        cnt_d[c] = '0;
      end else if (cnt_q[c] < CNT_MAX) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
      stable_d[c] = (cnt_d[c] == CNT_MAX);

      // Only a word that has sat unchanged in p for the full window may be committed,
      // which keeps skewed bit arrivals from ever producing an intermediate output.
      if (cnt_q[c] == CNT_MAX && s_val == p_q[c] && p_q[c] != out_q[c] && !freeze) begin
        out_d[c]     = p_q[c];
        updated_d[c] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int n = 0; n < SYNC_STAGES; n++) begin
          sync_q[c][n] <= INIT_VALUE;
        end
        p_q[c]   <= INIT_VALUE;
        out_q[c] <= INIT_VALUE;
        cnt_q[c] <= '0;
      end
      updated_q <= '0;
      stable_q  <= '0;
    end else begin
      sync_q    <= sync_d;
      p_q       <= p_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      updated_q <= updated_d;
      stable_q  <= stable_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
      assign bits_out[g*NUM_BITS +: NUM_BITS] = out_q[g];
    end
  endgenerate

  assign updated = updated_q;
  assign stable  = stable_q;

endmodule

// File: tb/tb_cdc_sync_data_stable.sv
// Directed bench for cdc_sync_data_stable: default instance plus a 4-channel,
// SYNC_STAGES=3, STABLE_CYCLES=1 instance sharing clock and reset.
module tb_cdc_sync_data_stable;

  logic       clk;
  logic       reset;
  logic       freeze;
  logic [3:0] bits_in;
  logic [3:0] bits_out;
  logic [1:0] updated;
  logic [1:0] stable;

  logic       freeze2;
  logic [7:0] bits_in2;
  logic [7:0] bits_out2;
  logic [3:0] updated2;
  logic [3:0] stable2;

  int errors;
  int checks;

  cdc_sync_data_stable dut (
    .clk      (clk),
    .reset    (reset),
    .bits_in  (bits_in),
    .freeze   (freeze),
    .bits_out (bits_out),
    .updated  (updated),
    .stable   (stable)
  );

  cdc_sync_data_stable #(
    .NUM_CHANNELS  (4),
    .NUM_BITS      (2),
    .SYNC_STAGES   (3),
    .STABLE_CYCLES (1)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .bits_in  (bits_in2),
    .freeze   (freeze2),
    .bits_out (bits_out2),
    .updated  (updated2),
    .stable   (stable2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    freeze   = 1'b0;
    bits_in  = 4'hF;
    freeze2  = 1'b0;
    bits_in2 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bits_out !== 4'h0 || updated !== 2'b00 || stable !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: out=%h upd=%b stb=%b, want out=0 upd=00 stb=00",
                 i, bits_out, updated, stable);
      end
    end
    checks++;
    if (bits_out2 !== 8'h00 || updated2 !== 4'h0 || stable2 !== 4'h0) begin
      errors++;
      $display("FAIL reset_dut2: out=%h upd=%b stb=%b, want all 0", bits_out2, updated2, stable2);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bits_out !== 4'h0 || updated !== 2'b00 || stable !== 2'b00) begin
      errors++;
      $display("FAIL reset_after: out=%h upd=%b stb=%b, want out=0 upd=00 stb=00",
               bits_out, updated, stable);
    end
    // A one-sample 0xF blip after release must be filtered out.
    bits_in = 4'h0;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (bits_out !== 4'h0 || updated !== 2'b00 || stable !== 2'b11) begin
      errors++;
      $display("FAIL reset_settle: out=%h upd=%b stb=%b, want out=0 upd=00 stb=11",
               bits_out, updated, stable);
    end
  endtask

  task automatic test_latency();
    bits_in = 4'b0010;
    step();                       // edge k
    for (int i = 1; i <= 6; i++) step();
    checks++;
    if (bits_out !== 4'b0000 || updated !== 2'b00) begin
      errors++;
      $display("FAIL latency_early: out=%b upd=%b at k+6, want out=0000 upd=00", bits_out, updated);
    end
    step();                       // edge k+7
    checks++;
    if (bits_out !== 4'b0010 || updated !== 2'b01) begin
      errors++;
      $display("FAIL latency_commit: out=%b upd=%b at k+7, want out=0010 upd=01", bits_out, updated);
    end
    step();
    checks++;
    if (bits_out !== 4'b0010 || updated !== 2'b00) begin
      errors++;
      $display("FAIL latency_pulse_end: out=%b upd=%b, want out=0010 upd=00", bits_out, updated);
    end
  endtask

  task automatic test_glitch();
    bit saw_stable_low;
    saw_stable_low = 1'b0;
    bits_in = 4'b1110;
    for (int i = 0; i < 3; i++) step();
    bits_in = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      step();
      if (stable[1] === 1'b0) saw_stable_low = 1'b1;
      checks++;
      if (bits_out !== 4'b0010 || updated !== 2'b00) begin
        errors++;
        $display("FAIL glitch_hold[%0d]: out=%b upd=%b, want out=0010 upd=00", i, bits_out, updated);
      end
    end
    checks++;
    if (saw_stable_low !== 1'b1 || stable !== 2'b11) begin
      errors++;
      $display("FAIL glitch_stable: saw_low=%b final_stb=%b, want saw_low=1 stb=11",
               saw_stable_low, stable);
    end
  endtask

  task automatic test_freeze();
    freeze  = 1'b1;
    bits_in = 4'b1101;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bits_out !== 4'b0010 || updated !== 2'b00) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: out=%b upd=%b, want out=0010 upd=00", i, bits_out, updated);
      end
    end
    checks++;
    if (stable !== 2'b11) begin
      errors++;
      $display("FAIL freeze_stable: stb=%b, want 11", stable);
    end
    freeze = 1'b0;
    step();
    checks++;
    if (bits_out !== 4'b1101 || updated !== 2'b11) begin
      errors++;
      $display("FAIL freeze_release: out=%b upd=%b, want out=1101 upd=11", bits_out, updated);
    end
    step();
    checks++;
    if (bits_out !== 4'b1101 || updated !== 2'b00) begin
      errors++;
      $display("FAIL freeze_pulse_end: out=%b upd=%b, want out=1101 upd=00", bits_out, updated);
    end
  endtask

  task automatic test_bit_skew();
    int pulses;
    bit saw_mid;
    pulses  = 0;
    saw_mid = 1'b0;
    bits_in = 4'b1100;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (bits_out !== 4'b1100) begin
      errors++;
      $display("FAIL skew_setup: out=%b, want 1100", bits_out);
    end
    bits_in = 4'b1101;
    step();
    step();
    bits_in = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      step();
      if (updated[0] === 1'b1) pulses++;
      if (bits_out[1:0] === 2'b01) saw_mid = 1'b1;
    end
    checks++;
    if (bits_out !== 4'b1111 || pulses != 1 || saw_mid !== 1'b0) begin
      errors++;
      $display("FAIL skew_result: out=%b pulses=%0d saw_01=%b, want out=1111 pulses=1 saw_01=0",
               bits_out, pulses, saw_mid);
    end
  endtask

  task automatic test_reset_mid();
    bits_in = 4'b1011;
    step();                       // edge k
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;                 // sampled at k+5 and k+6, commit was due at k+7
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bits_out !== 4'b0000 || updated !== 2'b00 || stable !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid[%0d]: out=%b upd=%b stb=%b, want 0000 00 00",
                 i, bits_out, updated, stable);
      end
    end
    reset = 1'b0;
    step();                       // k+7
    checks++;
    if (bits_out !== 4'b0000 || updated !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_no_commit: out=%b upd=%b, want out=0000 upd=00", bits_out, updated);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (bits_out !== 4'b1011) begin
      errors++;
      $display("FAIL reset_mid_recover: out=%b, want 1011", bits_out);
    end
  endtask

  task automatic test_params();
    bits_in2 = 8'b01_10_11_01;
    step();                       // edge k
    for (int i = 1; i <= 4; i++) step();
    checks++;
    if (bits_out2 !== 8'h00 || updated2 !== 4'b0000) begin
      errors++;
      $display("FAIL p2_early: out=%b upd=%b at k+4, want out=0 upd=0000", bits_out2, updated2);
    end
    step();                       // edge k+5
    checks++;
    if (bits_out2 !== 8'b01_10_11_01 || updated2 !== 4'b1111) begin
      errors++;
      $display("FAIL p2_commit: out=%b upd=%b, want out=01101101 upd=1111", bits_out2, updated2);
    end
    step();
    bits_in2 = 8'b01_00_11_01;    // only channel 2 changes
    step();
    for (int i = 1; i <= 4; i++) step();
    checks++;
    if (bits_out2 !== 8'b01_10_11_01 || updated2 !== 4'b0000) begin
      errors++;
      $display("FAIL p2_ch2_early: out=%b upd=%b, want out=01101101 upd=0000", bits_out2, updated2);
    end
    step();
    checks++;
    if (bits_out2 !== 8'b01_00_11_01 || updated2 !== 4'b0100) begin
      errors++;
      $display("FAIL p2_ch2_commit: out=%b upd=%b, want out=01001101 upd=0100", bits_out2, updated2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_freeze();
    test_bit_skew();
    test_reset_mid();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
